// File: rtl/h264_dc_quantise.sv
`default_nettype none
// ============================================================================
// h264_dc_quantise : H.264 chroma DC forward quantiser feeding an output FIFO.
// Optional H264_DC_QUANT_SAT_EN clamps levels to 12 bits and adds a SAT port.
// Revision: 1.0
// ============================================================================
module h264_dc_quantise #(
   parameter int INTRA = 1,
   parameter int DEPTH = 8
) (
   input  logic               CLK2,
   input  logic               RESETN,
   input  logic [5:0]         QP,
   output logic               READYI,
   input  logic               ENABLE,
   input  logic signed [15:0] XXIN,
   output logic               VALID,
   output logic signed [11:0] YYOUT,
   output logic               LAST,
   output logic               NZ,
   input  logic               READYO,
`ifdef H264_DC_QUANT_SAT_EN
   output logic               SAT,
`endif
   output logic               OVF
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int UW = CW + 1;
`ifdef H264_DC_QUANT_SAT_EN
   localparam int EW = 15;
`else
   localparam int EW = 14;
`endif

   // ---------------------------------------------------------------- group / QP
   logic [1:0]  grp_idx;
   logic [5:0]  qp_held;
   logic [5:0]  qp_clip;
   logic [5:0]  qp_use;
   logic [3:0]  qp_div;
   logic [2:0]  qp_mod;
   logic [13:0] mf;

   assign qp_clip = (QP > 6'd51) ? 6'd51 : QP;
   // QP is taken live on index 0 so the group's first coefficient sees it too
   assign qp_use  = (grp_idx == 2'd0) ? qp_clip : qp_held;

   always_comb begin
      qp_div = 4'(qp_use / 6'd6);
      qp_mod = 3'(qp_use % 6'd6);
      case (qp_mod)
         3'd0:    mf = 14'd13107;
         3'd1:    mf = 14'd11916;
         3'd2:    mf = 14'd10082;
         3'd3:    mf = 14'd9362;
         3'd4:    mf = 14'd8192;
         3'd5:    mf = 14'd7282;
         default: mf = 14'd13107;
      endcase
   end

   always_ff @(posedge CLK2 or negedge RESETN) begin
      if (!RESETN) begin
         grp_idx <= 2'd0;
         qp_held <= 6'd0;
      end else if (ENABLE) begin
         grp_idx <= grp_idx + 2'd1;
         if (grp_idx == 2'd0)
            qp_held <= qp_clip;
      end
   end

   // ---------------------------------------------------------------- stage 1
   logic [16:0] xin_ext;
   logic [16:0] xin_abs;
   logic        s1_valid;
   logic        s1_sign;
   logic [16:0] s1_abs;
   logic [1:0]  s1_idx;
   logic [13:0] s1_mf;
   logic [3:0]  s1_div;

   assign xin_ext = {XXIN[15], XXIN};
   assign xin_abs = XXIN[15] ? (17'd0 - xin_ext) : xin_ext;

   always_ff @(posedge CLK2 or negedge RESETN) begin
      if (!RESETN) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_abs   <= 17'd0;
         s1_idx   <= 2'd0;
         s1_mf    <= 14'd0;
         s1_div   <= 4'd0;
      end else begin
         s1_valid <= ENABLE;
         if (ENABLE) begin
            s1_sign <= XXIN[15];
            s1_abs  <= xin_abs;
            s1_idx  <= grp_idx;
            s1_mf   <= mf;
            s1_div  <= qp_div;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic        s2_valid;
   logic        s2_sign;
   logic [1:0]  s2_idx;
   logic [30:0] s2_prod;
   logic [3:0]  s2_div;

   always_ff @(posedge CLK2 or negedge RESETN) begin
      if (!RESETN) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_idx   <= 2'd0;
         s2_prod  <= 31'd0;
         s2_div   <= 4'd0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sign <= s1_sign;
            s2_idx  <= s1_idx;
            s2_prod <= 31'(s1_abs) * 31'(s1_mf);
            s2_div  <= s1_div;
         end
      end
   end

   // ---------------------------------------------------------------- stage 3
   logic [23:0]   rnd_off;
   logic [30:0]   rnd_sum;
   logic [4:0]    shamt;
   logic [14:0]   mag;
   logic          lvl_nz;
   logic [11:0]   lvl_red;
   logic [EW-1:0] s3_next;
   logic [EW-1:0] s3_entry;
   logic          s3_valid;
   logic          nz_acc;
`ifdef H264_DC_QUANT_SAT_EN
   logic          sat_hit;
`endif

   always_comb begin
      // floor(2^s/3) is the alternating 0101.. pattern truncated to s-1 bits
      rnd_off = (INTRA != 0) ? (24'h555555 >> (4'd8 - s2_div))
                             : (24'h555555 >> (4'd9 - s2_div));
      rnd_sum = s2_prod + {7'd0, rnd_off};
      shamt   = 5'd16 + {1'b0, s2_div};
      mag     = 15'(rnd_sum >> shamt);
      lvl_nz  = (mag != 15'd0);
      lvl_red = s2_sign ? (12'd0 - mag[11:0]) : mag[11:0];
`ifdef H264_DC_QUANT_SAT_EN
      sat_hit = 1'b0;
      if (!s2_sign && (mag > 15'd2047)) begin
         lvl_red = 12'h7FF;
         sat_hit = 1'b1;
      end else if (s2_sign && (mag > 15'd2048)) begin
         lvl_red = 12'h800;
         sat_hit = 1'b1;
      end
`endif
      s3_next       = '0;
      s3_next[11:0] = lvl_red;
      s3_next[12]   = (s2_idx == 2'd3);
      s3_next[13]   = (s2_idx == 2'd3) && (nz_acc || lvl_nz);
`ifdef H264_DC_QUANT_SAT_EN
      s3_next[14]   = sat_hit;
`endif
   end

   always_ff @(posedge CLK2 or negedge RESETN) begin
      if (!RESETN) begin
         s3_valid <= 1'b0;
         s3_entry <= '0;
         nz_acc   <= 1'b0;
      end else begin
         s3_valid <= s2_valid;
         if (s2_valid) begin
            s3_entry <= s3_next;
            nz_acc   <= (s2_idx == 2'd3) ? 1'b0 : (nz_acc || lvl_nz);
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          pop;
   logic          push;
   logic [UW-1:0] used;

   assign head = mem[rd_ptr];
   assign full = (count == CW'(DEPTH));
   assign pop  = (count != CW'(0)) && READYO;
   // a full FIFO still takes the write when the head leaves on the same edge
   assign push = s3_valid && (!full || pop);

   assign used   = UW'(count) + UW'(s1_valid) + UW'(s2_valid) + UW'(s3_valid);
   assign READYI = (used <= UW'(DEPTH - 4));

   always_ff @(posedge CLK2) begin
      if (push)
         mem[wr_ptr] <= s3_entry;
   end

   always_ff @(posedge CLK2 or negedge RESETN) begin
      if (!RESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         OVF    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (s3_valid && full && !pop)
            OVF <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- output
   always_ff @(posedge CLK2 or negedge RESETN) begin
      if (!RESETN) begin
         VALID <= 1'b0;
         YYOUT <= 12'sd0;
         LAST  <= 1'b0;
         NZ    <= 1'b0;
`ifdef H264_DC_QUANT_SAT_EN
         SAT   <= 1'b0;
`endif
      end else if (pop) begin
         VALID <= 1'b1;
         YYOUT <= head[11:0];
         LAST  <= head[12];
         NZ    <= head[13];
`ifdef H264_DC_QUANT_SAT_EN
         SAT   <= head[14];
`endif
      end else begin
         VALID <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_h264_dc_quantise.sv
`default_nettype none
// Directed self-checking bench for h264_dc_quantise (intra and inter instances).
module tb_h264_dc_quantise;

   logic               clk = 1'b0;
   logic               resetn;
   logic [5:0]         qp;
   logic               enable;
   logic signed [15:0] xxin;
   logic               readyo;

   logic               readyi_a, valid_a, last_a, nz_a, ovf_a;
   logic signed [11:0] yy_a;
   logic               readyi_b, valid_b, last_b, nz_b, ovf_b;
   logic signed [11:0] yy_b;
`ifdef H264_DC_QUANT_SAT_EN
   logic               sat_a, sat_b;
   int                 esat [4];
   localparam int      SAT_YY = 2047;
`else
   localparam int      SAT_YY = -1639;
`endif

   int                 n_checks = 0;
   int                 n_fail   = 0;
   logic signed [15:0] xin [4];
   int                 ea [4];
   int                 eb [4];
   int                 drain [8];

   always #5 clk = ~clk;

   h264_dc_quantise #(.INTRA(1), .DEPTH(8)) u_dut_intra (
      .CLK2(clk), .RESETN(resetn), .QP(qp), .READYI(readyi_a), .ENABLE(enable),
      .XXIN(xxin), .VALID(valid_a), .YYOUT(yy_a), .LAST(last_a), .NZ(nz_a),
      .READYO(readyo),
`ifdef H264_DC_QUANT_SAT_EN
      .SAT(sat_a),
`endif
      .OVF(ovf_a)
   );

   h264_dc_quantise #(.INTRA(0), .DEPTH(8)) u_dut_inter (
      .CLK2(clk), .RESETN(resetn), .QP(qp), .READYI(readyi_b), .ENABLE(enable),
      .XXIN(xxin), .VALID(valid_b), .YYOUT(yy_b), .LAST(last_b), .NZ(nz_b),
      .READYO(readyo),
`ifdef H264_DC_QUANT_SAT_EN
      .SAT(sat_b),
`endif
      .OVF(ovf_b)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one group (QP switched to q_mid after the first coefficient) and check its output.
   task automatic run_group(input string tag, input logic [5:0] q, input logic [5:0] q_mid,
                            input int enz, input bit use_b);
      int got;
      int cyc;
      readyo = 1'b1;
      qp     = q;
      for (int i = 0; i < 4; i++) begin
         enable = 1'b1;
         xxin   = xin[i];
         if (i == 1) qp = q_mid;
         tick();
      end
      enable = 1'b0;
      xxin   = 16'sd0;
      chk({tag, "_early"}, int'(valid_a), 0);
      got = 0;
      cyc = 3;
      while (got < 4 && cyc < 20) begin
         tick();
         cyc++;
         if (valid_a) begin
            if (got == 0) chk({tag, "_lat"}, cyc, 4);
            chk($sformatf("%s_yy%0d", tag, got), int'(yy_a), ea[got]);
            chk($sformatf("%s_last%0d", tag, got), int'(last_a), (got == 3) ? 1 : 0);
            chk($sformatf("%s_nz%0d", tag, got), int'(nz_a), (got == 3) ? enz : 0);
`ifdef H264_DC_QUANT_SAT_EN
            chk($sformatf("%s_sat%0d", tag, got), int'(sat_a), esat[got]);
`endif
            if (use_b) chk($sformatf("%s_inter_yy%0d", tag, got), int'(yy_b), eb[got]);
            got++;
         end
      end
      chk({tag, "_count"}, got, 4);
      tick();
      chk({tag, "_idle"}, int'(valid_a), 0);
      chk({tag, "_hold"}, int'(yy_a), ea[3]);
   endtask

   task automatic push4();
      for (int i = 0; i < 4; i++) begin
         enable = 1'b1;
         xxin   = xin[i];
         tick();
      end
      enable = 1'b0;
      xxin   = 16'sd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      resetn = 1'b0;
      enable = 1'b0;
      readyo = 1'b1;
      qp     = 6'd0;
      xxin   = 16'sd0;
`ifdef H264_DC_QUANT_SAT_EN
      esat = '{0, 0, 0, 0};
`endif
      tick();
      tick();
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_yy", int'(yy_a), 0);
      chk("rst_ovf", int'(ovf_a), 0);
      resetn = 1'b1;
      tick();
      chk("rst_readyi", int'(readyi_a), 1);

      xin = '{16'sd100, -16'sd100, 16'sd0, 16'sd5};
      ea  = '{20, -20, 0, 1};
      run_group("qp0", 6'd0, 6'd0, 1, 1'b0);

      xin = '{16'sd1000, 16'sd42, 16'sd42, 16'sd42};
      ea  = '{8, 0, 0, 0};
      run_group("qp28a", 6'd28, 6'd0, 1, 1'b0);
      xin = '{16'sd42, 16'sd42, 16'sd42, 16'sd42};
      ea  = '{0, 0, 0, 0};
      run_group("qp28b", 6'd28, 6'd0, 0, 1'b0);

      xin = '{16'sd5, 16'sd2, 16'sd4, -16'sd4};
      ea  = '{1, 0, 1, -1};
      eb  = '{1, 0, 0, 0};
      run_group("round", 6'd0, 6'd0, 1, 1'b1);

      xin = '{16'sd32767, 16'sd0, 16'sd0, 16'sd0};
      ea  = '{SAT_YY, 0, 0, 0};
`ifdef H264_DC_QUANT_SAT_EN
      esat = '{1, 0, 0, 0};
`endif
      run_group("big", 6'd0, 6'd0, 1, 1'b0);
`ifdef H264_DC_QUANT_SAT_EN
      esat = '{0, 0, 0, 0};
`endif

      xin = '{16'sd32767, -16'sd32768, 16'sd1000, 16'sd0};
      ea  = '{18, -18, 0, 0};
      run_group("qp63", 6'd63, 6'd0, 1, 1'b0);

      // FIFO fill with READYO low, overflow, then in-order drain
      readyo = 1'b0;
      qp     = 6'd0;
      chk("ovf_rdy0", int'(readyi_a), 1);
      xin = '{16'sd100, -16'sd100, 16'sd0, 16'sd5};
      push4();
      chk("ovf_rdy_mid", int'(readyi_a), 1);
      xin = '{16'sd5, 16'sd2, 16'sd4, -16'sd4};
      push4();
      chk("ovf_rdy_low", int'(readyi_a), 0);
      repeat (4) tick();
      chk("ovf_pre", int'(ovf_a), 0);
      chk("ovf_valid_off", int'(valid_a), 0);
      xin = '{16'sd700, 16'sd700, 16'sd700, 16'sd700};
      push4();
      repeat (4) tick();
      chk("ovf_set", int'(ovf_a), 1);
      drain = '{20, -20, 0, 1, 1, 0, 1, -1};
      readyo = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 8; c++) begin
         tick();
         if (valid_a) begin
            chk($sformatf("drain_yy%0d", got), int'(yy_a), drain[got]);
            chk($sformatf("drain_last%0d", got), int'(last_a), (got % 4 == 3) ? 1 : 0);
            got++;
         end
      end
      chk("drain_count", got, 8);
      tick();
      chk("drain_empty", int'(valid_a), 0);
      chk("ovf_sticky", int'(ovf_a), 1);

      // asynchronous reset during the third coefficient, QP changed mid-group
      qp     = 6'd0;
      enable = 1'b1;
      xxin   = 16'sd100;
      tick();
      qp   = 6'd28;
      xxin = 16'sd200;
      tick();
      xxin = 16'sd300;
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_valid", int'(valid_a), 0);
      chk("arst_yy", int'(yy_a), 0);
      chk("arst_last", int'(last_a), 0);
      chk("arst_nz", int'(nz_a), 0);
      chk("arst_ovf", int'(ovf_a), 0);
      enable = 1'b0;
      xxin   = 16'sd0;
      tick();
      resetn = 1'b1;
      tick();
      chk("arst_readyi", int'(readyi_a), 1);
      chk("arst_empty", int'(valid_a), 0);
      xin = '{16'sd1000, 16'sd42, 16'sd42, 16'sd42};
      ea  = '{8, 0, 0, 0};
      run_group("post_rst", 6'd28, 6'd0, 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
